// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : PC holder and single-outstanding instruction fetcher that
//            presents each word to the control unit via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    typedef enum logic [1:0] {
        START = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);

    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pcNext;
    logic [ADDR_W-1:0] r_pcOut;
    logic [ADDR_W-1:0] w_target;
    logic [31:0]       r_instr;
    logic              r_discard;
    logic              w_discardNext;
    logic              w_load;
    logic              w_unusedTargetLsbs;

    // Branch targets are word aligned; the low address bits carry no meaning.
    assign w_target           = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign w_unusedTargetLsbs = ^redirect_pc_i[1:0];

    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_discardNext = r_discard;
        w_load        = 1'b0;
        case (r_state)
            START: begin
                w_stateNext = REQ;
                if (redirect_i) w_pcNext = w_target;
            end
            REQ: begin
                if (redirect_i) w_pcNext = w_target;
                if (imem_gnt_i) begin
                    w_stateNext = WAIT;
                    // The granted word belongs to the old path and must be dropped.
                    if (redirect_i) w_discardNext = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    w_discardNext = 1'b0;
                    if (redirect_i) begin
                        w_pcNext    = w_target;
                        w_stateNext = REQ;
                    end else if (r_discard) begin
                        w_stateNext = REQ;
                    end else begin
                        w_load      = 1'b1;
                        w_stateNext = HOLD;
                    end
                end else if (redirect_i) begin
                    w_pcNext      = w_target;
                    w_discardNext = 1'b1;
                end
            end
            HOLD: begin
                // A redirect overrides the handshake; no sequential advance then.
                if (redirect_i) begin
                    w_pcNext    = w_target;
                    w_stateNext = REQ;
                end else if (instr_ready_i) begin
                    w_pcNext    = r_pc + C_PC_STEP;
                    w_stateNext = REQ;
                end
            end
            default: w_stateNext = START;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= START;
            r_pc      <= RESET_PC;
            r_pcOut   <= RESET_PC;
            r_instr   <= 32'h0000_0000;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pc      <= w_pcNext;
            r_discard <= w_discardNext;
            if (w_load) begin
                r_instr <= imem_rdata_i;
                r_pcOut <= r_pc;
            end
        end
    end

    assign imem_req_o    = (r_state == REQ);
    assign imem_addr_o   = r_pc;
    assign instr_valid_o = (r_state == HOLD);
    assign instr_o       = r_instr;
    assign op_o          = r_instr[31:26];
    assign funct_o       = r_instr[5:0];
    assign pc_o          = r_pcOut;
    assign pc_plus4_o    = r_pcOut + C_PC_STEP;

endmodule
`default_nettype wire
